// File: rtl/defs.sv
// defs: RV32I core-wide widths, major opcodes and ALU control encodings.
package defs;
  localparam int XLEN = 32;
  localparam int RF_PNTR_WIDTH = 5;
  localparam logic [6:0] OP_AL_R     = 7'b0110011;
  localparam logic [6:0] OP_AL_I     = 7'b0010011;
  localparam logic [6:0] OP_AL_B     = 7'b1100011;
  localparam logic [6:0] OP_AL_JAL   = 7'b1101111;
  localparam logic [6:0] OP_AL_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AL_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AL_AUIPC = 7'b0010111;
  typedef enum logic [3:0] {
    ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
    ALU_OP_XOR, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND,
    ALU_OP_INVALID = 4'hf
  } alu_op_type;
  typedef enum logic [2:0] {
    ALU_IN_REG, ALU_IN_IMM, ALU_IN_SHAMT, ALU_IN_PC, ALU_IN_PC_NEXT, ALU_IN_NULL
  } alu_in_type;
endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: fetch-side and execute-side handshake bundle of the decode stage.
interface id_stage_if import defs::*; #(
  parameter int XLEN = defs::XLEN,
  parameter int RF_PNTR_WIDTH = defs::RF_PNTR_WIDTH
);
  logic flush;
  logic in_valid, in_ready;
  logic [31:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic out_valid, out_ready;
  logic [XLEN-1:0] out_pc, out_imm;
  logic [RF_PNTR_WIDTH-1:0] out_rs1, out_rs2, out_rd;
  logic out_rd_we;
  alu_op_type out_alu_op;
  alu_in_type out_alu_in_a, out_alu_in_b;
  logic [2:0] out_func3;
  logic out_branch, out_jump, out_illegal;
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd, out_rd_we,
    input out_alu_op, out_alu_in_a, out_alu_in_b, out_func3, out_branch, out_jump, out_illegal
  );
  modport slave (
    input flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd, out_rd_we,
    output out_alu_op, out_alu_in_a, out_alu_in_b, out_func3, out_branch, out_jump, out_illegal
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: RV32I decode into a single registered slot with back-pressure and flush.
module id_stage import defs::*; #(
  parameter int XLEN = defs::XLEN,
  parameter int RF_PNTR_WIDTH = defs::RF_PNTR_WIDTH
) (
  input logic clk,
  input logic rst_n,
  id_stage_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [RF_PNTR_WIDTH-1:0] rs1, rs2, rd;
    logic rd_we;
    logic [XLEN-1:0] imm;
    alu_op_type alu_op;
    alu_in_type alu_in_a, alu_in_b;
    logic [2:0] func3;
    logic branch, jump, illegal;
  } slot_t;
  logic [31:0] w;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic f7_zero, f7_alt, acc, valid;
  logic [XLEN-1:0] imm_i, imm_b, imm_j, imm_u;
  alu_op_type base;
  slot_t d, q;
  assign w = bus.in_instr;
  assign opc = w[6:0];
  assign f3 = w[14:12];
  assign f7 = w[31:25];
  assign f7_zero = f7 == 7'h00;
  assign f7_alt = f7 == 7'h20;
  assign imm_i = XLEN'($signed(w[31:20]));
  assign imm_b = XLEN'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({w[31:12], 12'b0}));
  always_comb begin
    base = ALU_OP_ADD;
    case (f3)
      3'd1: base = ALU_OP_SLL;
      3'd2: base = ALU_OP_SLT;
      3'd3: base = ALU_OP_SLTU;
      3'd4: base = ALU_OP_XOR;
      3'd5: base = ALU_OP_SRL;
      3'd6: base = ALU_OP_OR;
      3'd7: base = ALU_OP_AND;
      default: base = ALU_OP_ADD;
    endcase
  end
  always_comb begin
    d = '0;
    d.pc = bus.in_pc;
    d.rs1 = RF_PNTR_WIDTH'(w[19:15]);
    d.rs2 = RF_PNTR_WIDTH'(w[24:20]);
    d.rd = RF_PNTR_WIDTH'(w[11:7]);
    d.func3 = f3;
    d.alu_op = ALU_OP_ADD;
    d.alu_in_a = ALU_IN_REG;
    d.alu_in_b = ALU_IN_REG;
    case (opc)
      OP_AL_R: begin
        d.alu_op = !f7_alt ? base : f3 == 3'd0 ? ALU_OP_SUB : ALU_OP_SRA;
        d.illegal = !(f7_zero || (f7_alt && (f3 == 3'd0 || f3 == 3'd5)));
      end
      OP_AL_I: begin
        d.alu_op = (f3 == 3'd5 && f7_alt) ? ALU_OP_SRA : base;
        d.alu_in_b = (f3 == 3'd1 || f3 == 3'd5) ? ALU_IN_SHAMT : ALU_IN_IMM;
        d.imm = imm_i;
        d.illegal = (f3 == 3'd1 && !f7_zero) || (f3 == 3'd5 && !f7_zero && !f7_alt);
      end
      OP_AL_B: begin
        d.alu_op = ALU_OP_SUB;
        d.imm = imm_b;
        d.branch = 1'b1;
        d.illegal = f3[2:1] == 2'b01;
      end
      OP_AL_JAL: begin
        d.alu_in_a = ALU_IN_PC_NEXT;
        d.alu_in_b = ALU_IN_NULL;
        d.imm = imm_j;
        d.jump = 1'b1;
      end
      OP_AL_JALR: begin
        d.alu_in_a = ALU_IN_PC_NEXT;
        d.alu_in_b = ALU_IN_NULL;
        d.imm = imm_i;
        d.jump = 1'b1;
        d.illegal = f3 != 3'd0;
      end
      OP_AL_LUI: begin
        d.alu_in_a = ALU_IN_NULL;
        d.alu_in_b = ALU_IN_IMM;
        d.imm = imm_u;
      end
      OP_AL_AUIPC: begin
        d.alu_in_a = ALU_IN_PC;
        d.alu_in_b = ALU_IN_IMM;
        d.imm = imm_u;
      end
      default: d.illegal = 1'b1;
    endcase
    d.rd_we = !d.illegal && opc != OP_AL_B && w[11:7] != 5'd0;
    // illegal words still travel down the pipe so execute can trap, but with inert controls
    if (d.illegal) begin
      d.alu_op = ALU_OP_INVALID;
      d.alu_in_a = ALU_IN_NULL;
      d.alu_in_b = ALU_IN_NULL;
      d.imm = '0;
      d.branch = 1'b0;
      d.jump = 1'b0;
    end
  end
  assign bus.in_ready = bus.flush || !valid || bus.out_ready;
  assign acc = bus.in_valid && bus.in_ready && !bus.flush;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      q <= '0;
    end else begin
      valid <= bus.flush ? 1'b0 : acc ? 1'b1 : bus.out_ready ? 1'b0 : valid;
      if (acc) q <= d;
    end
  assign bus.out_valid = valid;
  assign bus.out_pc = q.pc;
  assign bus.out_rs1 = q.rs1;
  assign bus.out_rs2 = q.rs2;
  assign bus.out_rd = q.rd;
  assign bus.out_rd_we = q.rd_we;
  assign bus.out_imm = q.imm;
  assign bus.out_alu_op = q.alu_op;
  assign bus.out_alu_in_a = q.alu_in_a;
  assign bus.out_alu_in_b = q.alu_in_b;
  assign bus.out_func3 = q.func3;
  assign bus.out_branch = q.branch;
  assign bus.out_jump = q.jump;
  assign bus.out_illegal = q.illegal;
endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode stage of the RV32I core. It takes one 32-bit instruction word and its PC from the fetch stage over a valid/ready handshake. It decodes the word into register pointers, a sign-extended immediate and ALU control (`alu_op_type`, `alu_in_type` from `defs`), and presents the result to the execute stage in a single registered pipeline slot. Supports back-pressure and a pipeline flush for branch/jump redirect.

## Interface
- `XLEN`, default `defs::XLEN` (32): instruction, PC and immediate width.
- `RF_PNTR_WIDTH`, default `defs::RF_PNTR_WIDTH` (5): register pointer width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush_i`  in  1  discard the held output and any instruction offered this cycle.
- `in_valid_i`  in  1  fetch offers an instruction.
- `in_ready_o`  out  1  stage accepts this cycle.
- `in_instr_i`  in  32  instruction word.
- `in_pc_i`  in  XLEN  PC of the instruction.
- `out_valid_o`  out  1  decoded slot is valid.
- `out_ready_i`  in  1  execute consumes the slot.
- `out_pc_o`  out  XLEN  registered PC.
- `out_rs1_o`, `out_rs2_o`, `out_rd_o`  out  5 each  register pointers.
- `out_rd_we_o`  out  1  register-file write enable.
- `out_imm_o`  out  XLEN  sign-extended immediate.
- `out_alu_op_o`  out  4  `alu_op_type`.
- `out_alu_in_a_o`, `out_alu_in_b_o`  out  3 each  `alu_in_type` operand selects.
- `out_func3_o`  out  3  raw func3 (branch condition for execute).
- `out_branch_o`, `out_jump_o`, `out_illegal_o`  out  1 each  class flags.

## Operation
- **Accept and hold**
  - Accept = `in_valid_i && in_ready_o && !flush_i`.
  - On accept, the payload registers load the decoded fields.
  - Otherwise the payload holds. No payload change without accept.
- **Decode by opcode.** The immediate is I/B/J/U per RV32I, sign-extended from bit 31.
  - `OP_AL_R`:
    - func3 000 → ADD (func7 0x00) or SUB (func7 0x20).
    - func3 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR.
    - func3 101 → SRL (func7 0x00) or SRA (func7 0x20).
    - func3 110 → OR; 111 → AND.
    - Any other func7 is illegal.
    - a=REG, b=REG, imm=0.
  - `OP_AL_I`:
    - func3 000/010/011/100/110/111 → ADD/SLT/SLTU/XOR/OR/AND with b=IMM.
    - func3 001 → SLL, func7 must be 0x00.
    - func3 101 → SRL (0x00) or SRA (0x20).
    - Shifts use b=SHAMT; execute takes the shift amount from `imm[4:0]`.
    - a=REG, I-immediate.
  - `OP_AL_B`:
    - op=SUB, a=REG, b=REG, B-immediate, branch=1, rd_we=0.
    - func3 010/011 is illegal.
  - `OP_AL_JAL`: op=ADD, a=PC_NEXT, b=NULL, J-immediate, jump=1.
  - `OP_AL_JALR`: op=ADD, a=PC_NEXT, b=NULL, I-immediate, jump=1. func3≠000 is illegal.
  - `OP_AL_LUI`: op=ADD, a=NULL, b=IMM, U-immediate.
  - `OP_AL_AUIPC`: op=ADD, a=PC, b=IMM, U-immediate.
  - Any other opcode is illegal.
- **Illegal instruction**
  - illegal=1, op=ALU_OP_INVALID, a=b=NULL.
  - rd_we=0, branch=0, jump=0, imm=0.
  - The slot is still delivered as valid so execute can trap.
- **Register pointers and write enable**
  - rs1/rs2/rd always equal instr[19:15]/[24:20]/[11:7].
  - rd_we=1 for R, I, JAL, JALR, LUI and AUIPC, only when rd≠0.

## Timing
- Latency 1 cycle: an instruction accepted at edge N is visible at `out_*` after edge N.
- `in_ready_o = flush_i || !out_valid_o || out_ready_i`. It is combinational from `out_ready_i` and `flush_i`.
- `out_valid_o` next-state:
  - 0 if `flush_i`.
  - Else 1 on accept.
  - Else 0 if `out_ready_i`.
  - Else hold.
- Accept and consume in the same cycle gives full throughput: one instruction per cycle.
- Back-pressure: while `out_valid_o && !out_ready_i`, all `out_*` are stable and `in_ready_o=0` (unless flush).
- Flush:
  - The held slot is dropped and `out_valid_o=0` the next cycle.
  - An instruction offered in the flush cycle is handshaken (ready=1) and discarded.
  - Flush with no valid slot is harmless.
- Reset (asynchronous, any time, including mid-stall):
  - `out_valid_o=0`.
  - pc/imm/rs*/rd/func3 = 0.
  - rd_we/branch/jump/illegal = 0.
  - alu_op=ALU_OP_ADD, a=b=ALU_IN_REG (encoding 0).
- Coming out of reset, `in_ready_o=1`.

## Test plan
- **ADD:** `0x002081B3` (add x3,x1,x2), pc 0x100 → next cycle:
  - valid=1, rs1=1, rs2=2, rd=3, rd_we=1.
  - op=ADD, a=REG, b=REG, pc_o=0x100.
- **SRAI:** `0x40335293` (srai x5,x6,3) → op=SRA, a=REG, b=SHAMT, imm=0x00000403, rd=5, rd_we=1.
- **BEQ:** `0xFE208EE3` (beq x1,x2,-4) → imm=0xFFFFFFFC, branch=1, func3=0, op=SUB, rd_we=0.
- **Back-pressure:**
  - Slot valid with `out_ready_i=0` for 3 cycles while a second instruction is offered → outputs unchanged and `in_ready_o=0` for all 3 cycles.
  - The second instruction is accepted the cycle `out_ready_i` rises and appears one cycle later.
- **Flush:** `flush_i=1` with slot valid and `in_valid_i=1` → next cycle `out_valid_o=0`; the offered instruction never appears at the output.
- **Illegal and reset:**
  - `0x00000000` → illegal=1, op=ALU_OP_INVALID, rd_we=0, valid=1.
  - Then drop `rst_n` mid-stall → all outputs return to reset values immediately, without waiting for a clock edge.
